// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the round-robin timer arbiter.
// rr_next is width-generic up to 16 requesters via zero-padding of req.
package timer_arb_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StDone
  } tarb_state_t;

  // First set bit at or after ptr, scanning modulo 16. Unused upper bits must be zero,
  // which makes the result identical to a modulo-N scan.
  function automatic logic [3:0] rr_next(input logic [3:0] ptr, input logic [15:0] req);
    logic [3:0] idx;
    rr_next = ptr;
    for (int k = 15; k >= 0; k--) begin
      idx = ptr + 4'(k);
      if (req[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/timer_arbiter_if.sv
// Requester-side bundle of the shared timer arbiter.
// master = requesters/timebase, slave = arbiter.
interface timer_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] delay_i;
  logic                   tick_en;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [ID_W-1:0]        cur_id;
  logic [CNT_W-1:0]       cnt_o;

  modport master (
    output req, delay_i, tick_en,
    input  gnt, done, busy, cur_id, cnt_o
  );

  modport slave (
    input  req, delay_i, tick_en,
    output gnt, done, busy, cur_id, cnt_o
  );

endinterface

// File: rtl/timer_arbiter_rr_pick.sv
// Combinational round-robin selector: request vector + pointer -> one-hot winner and index.
// Reusable by any shared resource with up to 16 requesters.
module rr_pick
  import timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  localparam int unsigned ID_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_valid,
  output logic [N_REQ-1:0] o_onehot,
  output logic [ID_W-1:0]  o_idx
);

  logic [3:0] w_idx;

  assign w_idx    = rr_next(4'(i_ptr), 16'(i_req));
  assign o_idx    = ID_W'(w_idx);
  assign o_valid  = |i_req;
  assign o_onehot = o_valid ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin arbiter sharing one loadable delay timer (D+1 enabled ticks) among N_REQ requesters.
// Define TIMER_ARB_ABORT_EN to let a grantee abort its run by dropping req during LOAD/RUN.
module timer_arbiter
  import timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic            clk,
  input logic            reset_n,
  timer_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(N_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

  tarb_state_t      r_state, w_state;
  logic [N_REQ-1:0] r_gnt, w_gnt;
  logic [N_REQ-1:0] r_done, w_done;
  logic             r_busy, w_busy;
  logic [ID_W-1:0]  r_cur_id, w_cur_id;
  logic [ID_W-1:0]  r_ptr, w_ptr;
  logic [ID_W-1:0]  w_ptr_inc;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [CNT_W-1:0] r_dly, w_dly;
  logic             w_pick_valid;
  logic [N_REQ-1:0] w_pick_onehot;
  logic [ID_W-1:0]  w_pick_idx;
  logic             w_abort;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_onehot(w_pick_onehot),
    .o_idx   (w_pick_idx)
  );

`ifdef TIMER_ARB_ABORT_EN
  assign w_abort = ~bus.req[r_cur_id];
`else
  assign w_abort = 1'b0;
`endif

  assign w_ptr_inc = (r_cur_id == LAST_ID) ? '0 : r_cur_id + 1'b1;

  always_comb begin
    w_state  = r_state;
    w_gnt    = r_gnt;
    w_done   = '0;
    w_cur_id = r_cur_id;
    w_ptr    = r_ptr;
    w_cnt    = r_cnt;
    w_dly    = r_dly;
    unique case (r_state)
      StIdle: begin
        if (w_pick_valid) begin
          w_state  = StLoad;
          w_gnt    = w_pick_onehot;
          w_cur_id = w_pick_idx;
        end
      end
      StLoad: begin
        if (w_abort) begin
          w_state = StIdle;
          w_gnt   = '0;
          w_cnt   = '0;
          w_ptr   = w_ptr_inc;
        end else begin
          w_dly   = bus.delay_i[r_cur_id*CNT_W +: CNT_W];
          w_cnt   = '0;
          w_state = StRun;
        end
      end
      StRun: begin
        if (w_abort) begin
          w_state = StIdle;
          w_gnt   = '0;
          w_cnt   = '0;
          w_ptr   = w_ptr_inc;
        end else if (bus.tick_en) begin
          // Terminal compare before increment: cnt saturates at D, never wraps.
          if (r_cnt == r_dly) begin
            w_state = StDone;
            w_done  = r_gnt;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      StDone: begin
        w_state = StIdle;
        w_gnt   = '0;
        w_ptr   = w_ptr_inc;
      end
      default: w_state = StIdle;
    endcase
    w_busy = (w_state != StIdle);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_gnt    <= '0;
      r_done   <= '0;
      r_busy   <= 1'b0;
      r_cur_id <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_dly    <= '0;
    end else begin
      r_state  <= w_state;
      r_gnt    <= w_gnt;
      r_done   <= w_done;
      r_busy   <= w_busy;
      r_cur_id <= w_cur_id;
      r_ptr    <= w_ptr;
      r_cnt    <= w_cnt;
      r_dly    <= w_dly;
    end
  end

  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.cur_id = r_cur_id;
  assign bus.cnt_o  = r_cnt;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: stimulus pushes predicted grants/dones computed from
// round-robin order and a precomputed tick pattern; a negedge monitor pops and compares.
module tb_timer_arbiter;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int TSZ = 30000;
  localparam int BIG = 1000000000;

  typedef struct {
    int id;
    int gcyc;
    int dcyc;
    int d;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  timer_arbiter_if #(.N_REQ(N), .CNT_W(W)) bus ();

  timer_arbiter #(
    .N_REQ(N),
    .CNT_W(W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         mptr = 0;
  int         last_done = -10;
  int         dly[N];
  bit         tick_pat[TSZ];
  bit         hold_req = 1'b0;
  logic [N-1:0] drop_mask = '0;
  exp_t       gq[$];
  exp_t       dq[$];

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle n is the interval after the n-th rising edge; tick_en for cycle n is tick_pat[n].
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      bus.tick_en = (cyc < TSZ) ? tick_pat[cyc] : 1'b0;
    end
  end

  // Requesters drop req on the cycle after their done pulse.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!hold_req) bus.req = bus.req & ~drop_mask;
      drop_mask = '0;
    end
  end

  function automatic int find_done(input int s, input int d);
    int n = 0;
    for (int c = s; c < TSZ; c++) begin
      if (tick_pat[c]) begin
        n++;
        if (n == d + 1) return c + 1;
      end
    end
    return BIG;
  endfunction

  task automatic fill_ticks(input int from, input int mode);
    for (int c = from; c < TSZ; c++) begin
      case (mode)
        0:       tick_pat[c] = 1'b1;
        1:       tick_pat[c] = (c % 3 == 0);
        default: tick_pat[c] = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  // Requests in 'set' all appear in idle cycle a; predicts every grant until the set drains.
  task automatic model_burst(input logic [N-1:0] set, input int a, input int n_grants,
                             output int dlast);
    logic [N-1:0] pend;
    int t, w, g, dc;
    pend  = set;
    t     = a;
    dlast = a;
    for (int k = 0; k < n_grants && pend != '0; k++) begin
      w = 0;
      for (int j = N - 1; j >= 0; j--) if (pend[(mptr + j) % N]) w = (mptr + j) % N;
      g  = t + 1;
      dc = find_done(g + 1, dly[w]);
      gq.push_back('{w, g, dc, dly[w]});
      dq.push_back('{w, g, dc, dly[w]});
      if (!hold_req) pend[w] = 1'b0;
      mptr  = (w + 1) % N;
      t     = dc + 1;
      dlast = dc;
    end
  endtask

  task automatic load_delays();
    for (int i = 0; i < N; i++) bus.delay_i[i*W +: W] = W'(dly[i]);
  endtask

  task automatic issue(input logic [N-1:0] set, input int mode, input int n_grants,
                       output int dlast);
    @(posedge clk);
    #2;
    fill_ticks(cyc + 1, mode);
    load_delays();
    model_burst(set, cyc, n_grants, dlast);
    bus.req = bus.req | set;
  endtask

  task automatic wait_done(input int dlast, input string name);
    int budget = 0;
    while ((cyc < dlast + 2 || gq.size() != 0 || dq.size() != 0) && budget < 4000) begin
      @(posedge clk);
      #2;
      budget++;
    end
    if (budget >= 4000) begin
      chk(1'b0, name, gq.size() + dq.size(), 0);
      gq.delete();
      dq.delete();
    end
  endtask

  // Monitor: compares every grant, count value and done pulse against the scoreboard.
  initial begin : monitor
    exp_t cur;
    exp_t e;
    logic [N-1:0] prev_gnt;
    bit active;
    int run_ticks;
    cur = '{0, 0, 0, 0};
    prev_gnt = '0;
    active = 1'b0;
    run_ticks = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk(bus.gnt == '0 && bus.done == '0 && !bus.busy && bus.cur_id == '0 && bus.cnt_o == '0,
            "reset_outputs", {bus.gnt, bus.done, bus.cnt_o}, 0);
        prev_gnt = '0;
        active = 1'b0;
        last_done = -10;
        continue;
      end
      chk($onehot0(bus.gnt), "gnt_onehot", bus.gnt, 0);
      chk($onehot0(bus.done), "done_onehot", bus.done, 0);
      if (bus.gnt != '0 && prev_gnt != '0) chk(bus.gnt == prev_gnt, "gnt_stable", bus.gnt, prev_gnt);
      if (bus.gnt != '0) chk(bus.busy, "busy_with_gnt", bus.busy, 1);
      if (bus.gnt != '0 && prev_gnt == '0) begin
        if (gq.size() == 0) begin
          chk(1'b0, "gnt_unexpected", bus.gnt, 0);
        end else begin
          e = gq.pop_front();
          chk(bus.gnt == N'(1) << e.id, "gnt_id", bus.gnt, N'(1) << e.id);
          chk(cyc == e.gcyc, "gnt_cycle", cyc, e.gcyc);
          chk(int'(bus.cur_id) == e.id, "cur_id", bus.cur_id, e.id);
          cur = e;
          active = 1'b1;
          run_ticks = 0;
        end
      end
      if (active && bus.gnt != '0 && cyc >= cur.gcyc + 1 && cyc < cur.dcyc) begin
        chk(int'(bus.cnt_o) == run_ticks, "cnt_value", bus.cnt_o, run_ticks);
        run_ticks += int'(tick_pat[cyc]);
      end
      if (bus.done != '0) begin
        if (dq.size() == 0) begin
          chk(1'b0, "done_unexpected", bus.done, 0);
        end else begin
          e = dq.pop_front();
          chk(bus.done == N'(1) << e.id, "done_id", bus.done, N'(1) << e.id);
          chk(cyc == e.dcyc, "done_cycle", cyc, e.dcyc);
          chk(bus.gnt == bus.done, "gnt_at_done", bus.gnt, bus.done);
          chk(int'(bus.cnt_o) == e.d, "cnt_at_done", bus.cnt_o, e.d);
        end
        drop_mask = drop_mask | bus.done;
        last_done = cyc;
      end
      if (cyc == last_done + 1)
        chk(bus.gnt == '0 && !bus.busy && bus.done == '0, "idle_after_done",
            {bus.gnt, bus.busy, bus.done}, 0);
      if (bus.gnt == '0) active = 1'b0;
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout, required completion (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int dl, budget, y;
    bus.req = '0;
    bus.delay_i = '0;
    bus.tick_en = 1'b0;
    for (int i = 0; i < N; i++) dly[i] = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Single request, delay changed after LOAD must not matter.
    dly[2] = 3;
    issue(4'b0100, 0, N, dl);
    @(posedge clk);
    @(posedge clk);
    #2;
    bus.delay_i[2*W +: W] = 8'd200;
    wait_done(dl, "single_timeout");

    // Boundary delays.
    dly[0] = 0;
    issue(4'b0001, 0, N, dl);
    wait_done(dl, "d0_timeout");
    dly[3] = 255;
    issue(4'b1000, 0, N, dl);
    wait_done(dl, "d255_timeout");

    // All four held: five grants in round-robin order, then release.
    for (int i = 0; i < N; i++) dly[i] = 1;
    hold_req = 1'b1;
    issue(4'b1111, 0, 5, dl);
    budget = 0;
    while (cyc < dl + 1 && budget < 2000) begin
      @(posedge clk);
      #2;
      budget++;
    end
    bus.req = '0;
    hold_req = 1'b0;
    wait_done(dl, "rr_timeout");

    // Gated timebase.
    dly[0] = 2;
    issue(4'b0001, 1, N, dl);
    wait_done(dl, "gated_timeout");

    // Reset in the middle of a run.
    dly[1] = 20;
    issue(4'b0010, 0, N, dl);
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(bus.gnt[1] && bus.cnt_o == 8'd5) && budget < 200);
    chk(budget < 200, "reset_wait_cnt5", budget, 0);
    #3;
    reset_n = 1'b0;
    #1;
    chk(bus.gnt == '0, "rst_gnt", bus.gnt, 0);
    chk(!bus.busy, "rst_busy", bus.busy, 0);
    chk(bus.cnt_o == '0, "rst_cnt", bus.cnt_o, 0);
    chk(bus.done == '0, "rst_done", bus.done, 0);
    gq.delete();
    dq.delete();
    mptr = 0;
    bus.req = '0;
    drop_mask = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // req[0] and req[3] with ptr freshly reset: 0 wins; drop req[0] at cnt=2.
    dly[0] = 6;
    dly[3] = 2;
`ifdef TIMER_ARB_ABORT_EN
    @(posedge clk);
    #2;
    fill_ticks(cyc + 1, 0);
    load_delays();
    gq.push_back('{0, cyc + 1, BIG, 6});
    bus.req = 4'b1001;
`else
    issue(4'b1001, 0, N, dl);
`endif
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (!(bus.gnt[0] && bus.cnt_o == 8'd2) && budget < 200);
    chk(budget < 200, "abort_wait_cnt2", budget, 0);
    #1;
    y = cyc;
    bus.req[0] = 1'b0;
`ifdef TIMER_ARB_ABORT_EN
    mptr = 1;
    model_burst(4'b1000, y + 1, N, dl);
    @(negedge clk);
    chk(!bus.busy && bus.gnt == '0 && bus.done == '0, "abort_idle",
        {bus.busy, bus.gnt, bus.done}, 0);
`endif
    wait_done(dl, "abort_timeout");

    // Fresh single request after the reset sequence.
    dly[1] = 4;
    issue(4'b0010, 0, N, dl);
    wait_done(dl, "fresh_timeout");

    // Randomized bursts.
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++)
        dly[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 40))
                                             : int'($urandom_range(0, 9));
      issue(N'($urandom_range(1, 15)), int'($urandom_range(0, 2)), N, dl);
      wait_done(dl, "random_timeout");
    end

    repeat (3) @(posedge clk);
    chk(gq.size() == 0 && dq.size() == 0, "queues_drained", gq.size() + dq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
